addr1_rd_arb: RTL

- Controller for the 8-entry x 10-bit 1W1R address table macro (registered read address, data valid the cycle after R0_en).
- Shares the single read port between two requesters using round-robin arbitration.
- Passes one write client straight through to the write port and tracks a per-entry valid bit.
- Returns read responses on a valid/ready channel with full backpressure. At most one read is outstanding.

---
 rtl/addr1_rd_arb.sv | 93 +++++++++
 1 files changed

// File: rtl/addr1_rd_arb.sv
// addr1_rd_arb: round-robin read arbiter, write pass-through and valid tracking for an 8x10 1W1R table (optional ADDR1_RD_ARB_PERF_EN conflict counter)
module addr1_rd_arb #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int DW    = 10
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          rd0_valid,
  input  logic [AW-1:0] rd0_addr,
  output logic          rd0_ready,
  input  logic          rd1_valid,
  input  logic [AW-1:0] rd1_addr,
  output logic          rd1_ready,
  input  logic          wr_valid,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          flush,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_id,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_hit,
  output logic          mem_W0_en,
  output logic [AW-1:0] mem_W0_addr,
  output logic [DW-1:0] mem_W0_data,
  output logic          mem_R0_en,
  output logic [AW-1:0] mem_R0_addr,
  input  logic [DW-1:0] mem_R0_data
`ifdef ADDR1_RD_ARB_PERF_EN
  ,
  output logic [15:0]   perf_conflict_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, RESP, HOLD} state_t;
  state_t state, state_nxt;
  logic rr_last, id_q, hit_q, can_issue, winner, grant;
  logic [AW-1:0] gaddr;
  logic [DW-1:0] hold_q;
  logic [DEPTH-1:0] vld, wr_bit;
  // arbitration, table port drive, response mux and next state
  always_comb begin
    rsp_valid   = state != IDLE;
    can_issue   = (state == IDLE) | (rsp_valid & rsp_ready);
    winner      = (rd0_valid & rd1_valid) ? ~rr_last : rd1_valid;
    grant       = can_issue & (rd0_valid | rd1_valid);
    rd0_ready   = grant & ~winner;
    rd1_ready   = grant & winner;
    gaddr       = winner ? rd1_addr : rd0_addr;
    mem_R0_en   = grant;
    mem_R0_addr = gaddr;
    mem_W0_en   = wr_valid;
    mem_W0_addr = wr_addr;
    mem_W0_data = wr_data;
    rsp_id      = id_q;
    rsp_hit     = hit_q;
    rsp_data    = (state == HOLD) ? hold_q : mem_R0_data;
    wr_bit      = wr_valid ? ({{(DEPTH-1){1'b0}}, 1'b1} << wr_addr) : '0;
    state_nxt   = grant ? RESP : can_issue ? IDLE : (state == RESP) ? HOLD : state;
  end
  // state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else state <= state_nxt;
  end
  // grant bookkeeping, stall capture and valid bits (flush before write)
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_last <= 1'b1;
      id_q    <= 1'b0;
      hit_q   <= 1'b0;
      hold_q  <= '0;
      vld     <= '0;
    end else begin
      if (grant) begin
        rr_last <= winner;
        id_q    <= winner;
        hit_q   <= vld[gaddr];
      end
      if (state == RESP && !rsp_ready) hold_q <= mem_R0_data;
      vld <= (flush ? '0 : vld) | wr_bit;
    end
  end
`ifdef ADDR1_RD_ARB_PERF_EN
  logic conflict;
  assign conflict = (rd0_valid & rd1_valid) | ((rd0_valid | rd1_valid) & ~can_issue);
  // saturating count of contended or blocked request cycles
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) perf_conflict_cnt <= '0;
    else if (conflict && perf_conflict_cnt != 16'hFFFF) perf_conflict_cnt <= perf_conflict_cnt + 16'd1;
  end
`endif
endmodule
